// File: rtl/fifo_ctrl.sv
// Pointer and flag sequencer for a single-clock fifo_mem array (UART TX/RX buffers).
// Optional sticky overflow/underflow flags are compiled in with `define FIFO_ERR_FLAG_EN.
module fifo_ctrl #(
  parameter int ASIZE  = 4,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
`ifdef FIFO_ERR_FLAG_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  output logic [ASIZE-1:0] mem_wr_addr,
  output logic [ASIZE-1:0] mem_rd_addr,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count
);

  localparam logic [ASIZE:0] ONE    = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] AF_CNT = (ASIZE+1)'(AF_LVL);
  localparam logic [ASIZE:0] AE_CNT = (ASIZE+1)'(AE_LVL);

  logic [ASIZE:0] wr_ptr_q, wr_ptr_d;
  logic [ASIZE:0] rd_ptr_q, rd_ptr_d;
  logic [ASIZE:0] count_q,  count_d;
  logic           rd_valid_q;
  logic           wr_acc, rd_acc;

  // Flags come only from registered state, so a request never sees its own effect.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ASIZE-1:0] == rd_ptr_q[ASIZE-1:0]) &&
                 (wr_ptr_q[ASIZE] != rd_ptr_q[ASIZE]);

  assign wr_acc = push & ~full;
  assign rd_acc = pop  & ~empty;

  assign mem_wr_en    = wr_acc;
  assign mem_rd_en    = rd_acc;
  assign mem_wr_addr  = wr_ptr_q[ASIZE-1:0];
  assign mem_rd_addr  = rd_ptr_q[ASIZE-1:0];
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // A new error event wins over a coincident clear.
  always_comb begin
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;
    if (push & full) overflow_d  = 1'b1;
    if (pop & empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Table-driven bench for fifo_ctrl with a scoreboard queue for the read-valid strobe.
`timescale 1ns/1ps
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push, pop;
  logic       mem_wr_en, mem_rd_en;
  logic [3:0] mem_wr_addr, mem_rd_addr;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef FIFO_ERR_FLAG_EN
  logic       err_clr, overflow, underflow;
`endif

  always #5 clk = ~clk;

  fifo_ctrl #(.ASIZE(4), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
`ifdef FIFO_ERR_FLAG_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .mem_wr_en    (mem_wr_en),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_rd_addr  (mem_rd_addr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
  );

  typedef struct packed {
    logic       push;
    logic       pop;
    logic       wr_en;  // expected mem_wr_en in the request cycle
    logic       rd_en;  // expected mem_rd_en in the request cycle
    logic [4:0] cnt;    // expected count after the edge
  } vec_t;

  vec_t tab[$];
  logic exp_rv[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_idx;
  int   split;
  logic [3:0] exp_wa, exp_ra;
  logic [4:0] prev_cnt;
  logic       exp_ovf, exp_udf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, vec_idx, act, exp);
    end
  endtask

  function automatic void add(input logic p, input logic q, input logic we,
                              input logic re, input int c);
    vec_t v;
    v.push = p; v.pop = q; v.wr_en = we; v.rd_en = re; v.cnt = 5'(c);
    tab.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    logic want_rv;
    push = v.push;
    pop  = v.pop;
    @(negedge clk);
    check("mem_wr_en",   {31'd0, mem_wr_en}, {31'd0, v.wr_en});
    check("mem_rd_en",   {31'd0, mem_rd_en}, {31'd0, v.rd_en});
    check("mem_wr_addr", {28'd0, mem_wr_addr}, {28'd0, exp_wa});
    check("mem_rd_addr", {28'd0, mem_rd_addr}, {28'd0, exp_ra});
    exp_rv.push_back(v.rd_en);
    if (v.push && prev_cnt == 5'd16) exp_ovf = 1'b1;
    if (v.pop  && prev_cnt == 5'd0)  exp_udf = 1'b1;
    @(posedge clk);
    #1;
    if (v.wr_en) exp_wa = exp_wa + 4'd1;
    if (v.rd_en) exp_ra = exp_ra + 4'd1;
    if (exp_rv.size() == 0) begin
      want_rv = 1'b0;
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      want_rv = exp_rv.pop_front();
    end
    check("rd_valid",     {31'd0, rd_valid}, {31'd0, want_rv});
    check("count",        {27'd0, count}, {27'd0, v.cnt});
    check("full",         {31'd0, full},         {31'd0, v.cnt == 5'd16});
    check("empty",        {31'd0, empty},        {31'd0, v.cnt == 5'd0});
    check("almost_full",  {31'd0, almost_full},  {31'd0, v.cnt >= 5'd14});
    check("almost_empty", {31'd0, almost_empty}, {31'd0, v.cnt <= 5'd2});
`ifdef FIFO_ERR_FLAG_EN
    check("overflow",  {31'd0, overflow},  {31'd0, exp_ovf});
    check("underflow", {31'd0, underflow}, {31'd0, exp_udf});
`endif
    prev_cnt = v.cnt;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},        {27'd0, count}, 32'd0);
    check({tag, "_empty"},        {31'd0, empty}, 32'd1);
    check({tag, "_almost_empty"}, {31'd0, almost_empty}, 32'd1);
    check({tag, "_full"},         {31'd0, full}, 32'd0);
    check({tag, "_almost_full"},  {31'd0, almost_full}, 32'd0);
    check({tag, "_rd_valid"},     {31'd0, rd_valid}, 32'd0);
    check({tag, "_wr_addr"},      {28'd0, mem_wr_addr}, 32'd0);
    check({tag, "_rd_addr"},      {28'd0, mem_rd_addr}, 32'd0);
`ifdef FIFO_ERR_FLAG_EN
    check({tag, "_overflow"},     {31'd0, overflow}, 32'd0);
    check({tag, "_underflow"},    {31'd0, underflow}, 32'd0);
`endif
  endtask

  task automatic clear_model();
    exp_wa   = '0;
    exp_ra   = '0;
    prev_cnt = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    exp_rv.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Segment A: fill, overfill, drain, underflow, simultaneous corners, partial refill.
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 0, 1, 0, i + 1);
    add(1, 0, 0, 0, 16);               // push while full is rejected
    add(1, 1, 0, 1, 15);               // push+pop at full: only pop
    add(1, 0, 1, 0, 16);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 1, 15 - i);
    add(0, 1, 0, 0, 0);                // pop while empty is rejected
    add(1, 1, 1, 0, 1);                // push+pop at empty: only push
    add(0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 1, 0, i + 1);
    add(0, 1, 0, 1, 7);                // count 7 with rd_valid pending at reset time
    split = tab.size();
    // Segment B (after mid-burst reset): wrap and simultaneous at count 5.
    for (int i = 0; i < 10; i++) add(1, 0, 1, 0, i + 1);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 1, 9 - i);
    for (int i = 0; i < 10; i++) add(1, 0, 1, 0, i + 1);
    for (int i = 0; i < 5; i++)  add(0, 1, 0, 1, 9 - i);
    add(1, 1, 1, 1, 5);
    add(0, 0, 0, 0, 5);

    vec_idx = -1;
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
`ifdef FIFO_ERR_FLAG_EN
    err_clr = 1'b0;
`endif
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < split; i++) begin
      vec_idx = i;
      apply(tab[i]);
    end

    // Asynchronous reset mid-burst: outputs must clear before any clock edge.
    vec_idx = -2;
    push = 1'b0;
    pop  = 1'b0;
    #2;
    check("pre_reset_count", {27'd0, count}, 32'd7);
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = split; i < tab.size(); i++) begin
      vec_idx = i;
      apply(tab[i]);
    end

`ifdef FIFO_ERR_FLAG_EN
    // Sticky flags clear on err_clr; a coincident error event wins.
    vec_idx = -3;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clr_overflow",  {31'd0, overflow},  32'd0);
    check("err_clr_underflow", {31'd0, underflow}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
